exp_reconstruct: RTL and testbench

Sequential back end of the fixed-point exponential datapath. It consumes one operand x together with the range-reduction lookup results for that operand: exp(a) and the breakpoint a, where a is x truncated to its top 8 fractional bits. It computes the residual r = x − a, approximates exp(r) ≈ 1 + r + r²/2, and returns exp(x) ≈ exp(a)·exp(r) in the same 3.23 unsigned format. Arithmetic uses shift-add iteration, and valid/ready handshakes are provided on both sides.

---
 rtl/exp_reconstruct.sv | 137 +++++++++++++
 tb/tb_exp_reconstruct.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exp_reconstruct.sv
// Back end of the fixed-point exp datapath: exp(x) = exp(a) * (1 + r + r^2/2),
// with r = x - a, computed by serial shift-add squaring and multiplication.
module exp_reconstruct #(
  parameter int num_of_int  = 3,
  parameter int num_of_frac = 23
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_valid,
  output logic                   IN_ready,
  input  logic [num_of_int-1:0]  IN_int,
  input  logic [num_of_frac-1:0] IN_frac,
  input  logic [num_of_int-1:0]  LUT_int,
  input  logic [num_of_frac-1:0] LUT_frac,
  input  logic [num_of_int-1:0]  LUT_a_int,
  input  logic [num_of_frac-1:0] LUT_a_frac,
  output logic                   OUT_valid,
  input  logic                   OUT_ready,
  output logic [num_of_int-1:0]  OUT_int,
  output logic [num_of_frac-1:0] OUT_frac,
  output logic                   OUT_err
);

  localparam int W     = num_of_int + num_of_frac;
  localparam int RW    = num_of_frac - 8;
  localparam int SQ_W  = 2 * RW;
  localparam int MUL_W = 2 * W;
  localparam int CW    = $clog2(W);

  localparam logic [CW-1:0] SQR_LAST = CW'(RW - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
  localparam logic [W-1:0]  ONE_FX   = W'(1) << num_of_frac;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t state, state_next;

  logic [RW-1:0]          r;
  logic [W-1:0]           ea;
  logic                   err;
  logic [W-1:0]           e_reg;
  logic [CW-1:0]          cnt;
  logic [SQ_W-1:0]        sq_acc;
  logic [MUL_W-1:0]       mul_acc;

  logic [num_of_frac-1:0] frac_diff;
  logic [SQ_W-1:0]        sq_add, sq_next;
  logic [MUL_W-1:0]       mul_add, mul_next;
  logic [W-1:0]           e_next;
  logic [W-1:0]           prod;

  assign IN_ready  = (state == IDLE);
  assign frac_diff = IN_frac - LUT_a_frac;

  // One partial product per cycle; the final partial product is folded in
  // combinationally so the last iteration's result is available at its edge.
  assign sq_add   = r[cnt[3:0]] ? (SQ_W'(r) << cnt) : '0;
  assign sq_next  = sq_acc + sq_add;
  assign e_next   = ONE_FX + W'(r) + W'(sq_next >> (num_of_frac + 1));
  assign mul_add  = e_reg[cnt] ? (MUL_W'(ea) << cnt) : '0;
  assign mul_next = mul_acc + mul_add;
  assign prod     = W'(mul_next >> num_of_frac);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (IN_valid)        state_next = SQR;
      SQR:  if (cnt == SQR_LAST) state_next = MUL;
      MUL:  if (cnt == MUL_LAST) state_next = DONE;
      DONE: if (OUT_ready)       state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r         <= '0;
      ea        <= '0;
      err       <= 1'b0;
      e_reg     <= '0;
      cnt       <= '0;
      sq_acc    <= '0;
      mul_acc   <= '0;
      OUT_valid <= 1'b0;
      OUT_int   <= '0;
      OUT_frac  <= '0;
      OUT_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_valid) begin
            r       <= RW'(frac_diff);
            ea      <= {LUT_int, LUT_frac};
            err     <= (IN_int != '0) | (IN_int != LUT_a_int);
            cnt     <= '0;
            sq_acc  <= '0;
            mul_acc <= '0;
          end
        end
        SQR: begin
          if (cnt == SQR_LAST) begin
            e_reg  <= e_next;
            sq_acc <= '0;
            cnt    <= '0;
          end else begin
            sq_acc <= sq_next;
            cnt    <= cnt + 1'b1;
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            // Out-of-domain operands still iterate so latency stays fixed.
            OUT_int   <= err ? '1 : prod[W-1:num_of_frac];
            OUT_frac  <= err ? '1 : prod[num_of_frac-1:0];
            OUT_err   <= err;
            OUT_valid <= 1'b1;
            mul_acc   <= '0;
            cnt       <= '0;
          end else begin
            mul_acc <= mul_next;
            cnt     <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (OUT_ready) OUT_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_reconstruct.sv
// Directed testbench for exp_reconstruct: latency, exactness, error path,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_exp_reconstruct;

  logic        CLK;
  logic        RST;
  logic        IN_valid;
  logic        IN_ready;
  logic [2:0]  IN_int;
  logic [22:0] IN_frac;
  logic [2:0]  LUT_int;
  logic [22:0] LUT_frac;
  logic [2:0]  LUT_a_int;
  logic [22:0] LUT_a_frac;
  logic        OUT_valid;
  logic        OUT_ready;
  logic [2:0]  OUT_int;
  logic [22:0] OUT_frac;
  logic        OUT_err;

  int checks = 0;
  int errors = 0;

  exp_reconstruct #(.num_of_int(3), .num_of_frac(23)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_valid  (IN_valid),
    .IN_ready  (IN_ready),
    .IN_int    (IN_int),
    .IN_frac   (IN_frac),
    .LUT_int   (LUT_int),
    .LUT_frac  (LUT_frac),
    .LUT_a_int (LUT_a_int),
    .LUT_a_frac(LUT_a_frac),
    .OUT_valid (OUT_valid),
    .OUT_ready (OUT_ready),
    .OUT_int   (OUT_int),
    .OUT_frac  (OUT_frac),
    .OUT_err   (OUT_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand and lets it be taken at the next edge, then scrambles
  // the inputs to show they are latched rather than sampled later.
  task automatic apply_stimulus(input logic [2:0] in_i, input logic [22:0] in_f,
                                input logic [2:0] lut_i, input logic [22:0] lut_f,
                                input logic [2:0] a_i, input logic [22:0] a_f);
    IN_int     = in_i;
    IN_frac    = in_f;
    LUT_int    = lut_i;
    LUT_frac   = lut_f;
    LUT_a_int  = a_i;
    LUT_a_frac = a_f;
    IN_valid   = 1'b1;
    check_eq("in_ready_idle", 32'(IN_ready), 32'd1);
    @(posedge CLK);
    #1;
    IN_valid   = 1'b0;
    IN_int     = 3'b101;
    IN_frac    = 23'h5A5A5A;
    LUT_int    = 3'b110;
    LUT_frac   = 23'h3C3C3C;
    LUT_a_int  = 3'b011;
    LUT_a_frac = 23'h7F0000;
  endtask

  task automatic wait_result(input string tag);
    repeat (20) @(posedge CLK);
    #1;
    check_eq({tag, "_busy"}, 32'(IN_ready), 32'd0);
    repeat (20) @(posedge CLK);
    #1;
    check_eq({tag, "_early"}, 32'(OUT_valid), 32'd0);
    @(posedge CLK);
    #1;
    check_eq({tag, "_latency"}, 32'(OUT_valid), 32'd1);
  endtask

  task automatic check_output(input string tag, input logic [2:0] exp_int,
                              input logic [22:0] exp_frac, input logic exp_err);
    check_eq({tag, "_int"},  32'(OUT_int),  32'(exp_int));
    check_eq({tag, "_frac"}, 32'(OUT_frac), 32'(exp_frac));
    check_eq({tag, "_err"},  32'(OUT_err),  32'(exp_err));
  endtask

  task automatic handshake(input string tag);
    OUT_ready = 1'b1;
    @(posedge CLK);
    #1;
    OUT_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(OUT_valid), 32'd0);
    check_eq({tag, "_idle"},       32'(IN_ready),  32'd1);
  endtask

  initial begin
    RST        = 1'b1;
    IN_valid   = 1'b0;
    IN_int     = '0;
    IN_frac    = '0;
    LUT_int    = '0;
    LUT_frac   = '0;
    LUT_a_int  = '0;
    LUT_a_frac = '0;
    OUT_ready  = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_in_ready",  32'(IN_ready),  32'd1);
    check_eq("rst_out_valid", 32'(OUT_valid), 32'd0);
    check_output("rst", 3'd0, 23'd0, 1'b0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    $display("[TB] x = 0");
    apply_stimulus(3'd0, 23'd0, 3'd1, 23'd0, 3'd0, 23'd0);
    wait_result("x0");
    check_output("x0", 3'd1, 23'd0, 1'b0);
    handshake("x0");

    $display("[TB] x = 0.5, r = 0 is exact");
    apply_stimulus(3'd0, 23'h400000, 3'd1, 23'h53094C, 3'd0, 23'h400000);
    wait_result("x05");
    check_output("x05", 3'd1, 23'h53094C, 1'b0);
    handshake("x05");

    $display("[TB] maximum residual");
    apply_stimulus(3'd0, 23'h007FFF, 3'd1, 23'd0, 3'd0, 23'd0);
    wait_result("rmax");
    check_output("rmax", 3'd1, 23'h00803E, 1'b0);
    handshake("rmax");

    // EA = 2.0, r = 256 ulp: r^2>>24 = 0, E = 2^23+256, result = 2 + 512 ulp
    $display("[TB] EA = 2, small residual");
    apply_stimulus(3'd0, 23'h000100, 3'd2, 23'd0, 3'd0, 23'd0);
    wait_result("ea2");
    check_output("ea2", 3'd2, 23'h000200, 1'b0);
    handshake("ea2");

    $display("[TB] domain error");
    apply_stimulus(3'd1, 23'h1234AB, 3'd2, 23'h2B7E15, 3'd1, 23'h120000);
    wait_result("derr");
    check_output("derr", 3'b111, 23'h7FFFFF, 1'b1);
    handshake("derr");

    $display("[TB] backpressure");
    apply_stimulus(3'd0, 23'd0, 3'd1, 23'd0, 3'd0, 23'd0);
    wait_result("bp");
    check_output("bp", 3'd1, 23'd0, 1'b0);
    IN_int     = 3'd0;
    IN_frac    = 23'h007FFF;
    LUT_int    = 3'd1;
    LUT_frac   = 23'd0;
    LUT_a_int  = 3'd0;
    LUT_a_frac = 23'd0;
    IN_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check_eq("bp_hold_valid", 32'(OUT_valid), 32'd1);
      check_eq("bp_hold_int",   32'(OUT_int),   32'd1);
      check_eq("bp_hold_frac",  32'(OUT_frac),  32'd0);
      check_eq("bp_in_ready",   32'(IN_ready),  32'd0);
    end
    handshake("bp");
    apply_stimulus(3'd0, 23'h007FFF, 3'd1, 23'd0, 3'd0, 23'd0);
    wait_result("bp2");
    check_output("bp2", 3'd1, 23'h00803E, 1'b0);
    handshake("bp2");

    $display("[TB] reset during MUL");
    apply_stimulus(3'd0, 23'h400000, 3'd1, 23'h53094C, 3'd0, 23'h400000);
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check_eq("mrst_in_ready",  32'(IN_ready),  32'd1);
    check_eq("mrst_out_valid", 32'(OUT_valid), 32'd0);
    check_output("mrst", 3'd0, 23'd0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (45) @(posedge CLK);
    #1;
    check_eq("mrst_no_stale_valid", 32'(OUT_valid), 32'd0);
    apply_stimulus(3'd0, 23'd0, 3'd1, 23'd0, 3'd0, 23'd0);
    wait_result("post");
    check_output("post", 3'd1, 23'd0, 1'b0);
    handshake("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
